prbs_checker: RTL and testbench
===============================

# prbs_checker

Receive-side bit-error checker for the emulated serial link. Consumes `rx_data` from the receive flip-flop, which is the output of the DUT sampled in the `rx_clk` domain. It self-synchronizes a local PRBS replica to the incoming stream, declares lock, and then counts received bits and bit errors. It runs on `emu_clk` and advances only on emulation steps where the time manager asserts `rx_clk_en`.

## Interface
Parameters:
- `PRBS_ORDER`, 7: LFSR length; polynomial x^7+x^6+1 (next = s[6]^s[5]); only 7 supported in this revision.
- `LOCK_COUNT`, 32: consecutive correct predictions required to declare lock.
- `WIN_LEN`, 64: error-monitoring window length in bits while locked.
- `UNLOCK_ERRS`, 8: errors within one window that force loss of lock.
- `CNT_W`, 32: width of bit and error counters.

Ports:
- `emu_clk`, input, 1: emulator clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `clk_en`, input, 1: `rx_clk_en` from the time manager; one received bit per enabled cycle.
- `rx_data`, input, 1: received bit.
- `clear`, input, 1: synchronous counter clear; does not affect lock.
- `locked`, output, 1: high in the LOCKED state.
- `err_flag`, output, 1: one-cycle pulse on a mismatched bit while LOCKED.
- `bit_count`, output, CNT_W: bits checked while LOCKED; saturating.
- `err_count`, output, CNT_W: errors while LOCKED; saturating.
- `state`, output, 2: current FSM state, for debug and ILA probing.

## Operation
The FSM has three states, encoded SEARCH=0, VERIFY=1, LOCKED=2. All transitions occur only on cycles where `clk_en`=1.
- **SEARCH:**
  - Shift `rx_data` into the LFSR, MSB first into s[0].
  - Count loaded bits; after `PRBS_ORDER` bits go to VERIFY.
- **VERIFY:**
  - Compare `rx_data` to the prediction s[6]^s[5].
  - On a match, advance the LFSR and increment the match counter; on reaching `LOCK_COUNT`, go to LOCKED.
  - On a mismatch, go to SEARCH, clearing the load and match counters; the mismatched bit is the first bit loaded.
- **LOCKED:**
  - The LFSR free-runs on its own prediction and is never reloaded from data.
  - Every bit increments `bit_count`.
  - A mismatch increments `err_count` and the window error counter and pulses `err_flag`.
  - The window counter counts enabled bits 0..`WIN_LEN`-1 and wraps.
  - If the window error counter reaches `UNLOCK_ERRS`, go to SEARCH and zero both window counters.
  - At wrap, zero the window error counter.
- The all-zero LFSR is illegal. If SEARCH completes loading with s==0, stay in SEARCH and reload.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- All outputs are registered and update on the `emu_clk` edge of the enabled cycle. Latency from `rx_data` to `err_flag`/counters is 1 `emu_clk` cycle.
- `clk_en`=0: all state, counters and `locked` hold; `err_flag` is 0.
- `rst` asserted at any time, including mid-lock, immediately forces SEARCH. `locked`, `err_flag`, `bit_count`, `err_count`, `state`, the LFSR and all internal counters go to 0.
- `clear`=1: `bit_count` and `err_count` go to 0 on that edge. `clear` overrides an increment in the same cycle; state, LFSR and window counters are unaffected.
- Error on the last bit of a window: the error is counted into the closing window first. The unlock check uses that total; the window then resets.
- Error that reaches `UNLOCK_ERRS`: that error is still counted in `err_count`. `locked` falls on the same edge.

## Structure
- Shared package `prbs_pkg`: `prbs_state_t` enum, `PRBS7_TAPS` constant, and the next-bit function. These are shared with the `prbs` transmit generator.
- Sub-module `prbs_lfsr`: shift register with `load_en`/`load_bit` and `adv_en` inputs and a `pred` output. It is reused by the generator.
- The checker holds the FSM, window logic and saturating counters.

## Test plan
- Reset, then a clean PRBS7 stream (seed 7'h7F) with `clk_en`=1 every cycle → `locked` rises on enabled bit 39 (7+32); `err_count`=0; `bit_count` increments from the following bit.
- Locked, invert one bit → `err_flag` pulses once, `err_count`=1, `locked` stays 1.
- Locked, invert 8 bits within one 64-bit window → `locked` falls on the edge of the 8th error, `err_count`=8, `state`=SEARCH; relock after 39 further clean bits.
- Locked, 7 errors in window 1 and 7 in window 2 → stays locked, `err_count`=14.
- `clk_en` toggled 1-in-3 with the stream held during gaps → same lock point (39 enabled bits) and identical counts to the continuous run.
- `CNT_W`=4, 20 locked bits → `bit_count` saturates at 15. Then assert `clear`, then `rst` mid-lock → counts go to 0 and `locked`=0 asynchronously on `rst`.

Source files
------------

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS7 types, taps and next-bit function
// Purpose: state encoding and polynomial helpers shared by the prbs
//          transmit generator and the prbs_checker receive side.
// Ports:   none (package).
package prbs_pkg;

    localparam int PRBS7_LEN = 7;

    // x^7 + x^6 + 1: feedback is s[6] ^ s[5]
    localparam logic [PRBS7_LEN-1:0] PRBS7_TAPS = 7'b110_0000;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_t;

    function automatic logic prbs7_next(input logic [PRBS7_LEN-1:0] s);
        return ^(s & PRBS7_TAPS);
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// rtl/prbs_lfsr.sv - PRBS7 shift register with data load and free-run advance
// Purpose: 7-bit Fibonacci LFSR. Loading shifts an external bit into s[0];
//          advancing shifts in its own prediction. Load wins over advance.
// Ports:   emu_clk, rst     - clock, async active-high reset (register -> 0)
//          load_en/load_bit - shift load_bit in
//          adv_en           - shift the prediction in
//          pred             - next expected bit, s[6] ^ s[5]
//          load_zero        - a load of load_bit now would leave s all-zero
module prbs_lfsr
    import prbs_pkg::*;
(
    input  logic emu_clk,
    input  logic rst,
    input  logic load_en,
    input  logic load_bit,
    input  logic adv_en,
    output logic pred,
    output logic load_zero
);

    logic [PRBS7_LEN-1:0] s;

    assign pred      = prbs7_next(s);
    assign load_zero = ({s[PRBS7_LEN-2:0], load_bit} == '0);

    always_ff @(posedge emu_clk or posedge rst) begin
        if (rst) begin
            s <= '0;
        end else if (load_en) begin
            s <= {s[PRBS7_LEN-2:0], load_bit};
        end else if (adv_en) begin
            s <= {s[PRBS7_LEN-2:0], pred};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronizing PRBS7 bit-error checker
// Purpose: syncs a local PRBS7 replica to rx_data, declares lock after
//          LOCK_COUNT clean predictions, then counts bits and errors with a
//          windowed loss-of-lock detector. Advances only when clk_en=1.
// Ports:   emu_clk, rst (async active-high), clk_en, rx_data, clear (sync
//          counter clear) in; locked, err_flag, bit_count, err_count, state out.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int PRBS_ORDER  = 7,
    parameter int LOCK_COUNT  = 32,
    parameter int WIN_LEN     = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic             emu_clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             rx_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_flag,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int LD_W = $clog2(PRBS_ORDER + 1);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WE_W = $clog2(UNLOCK_ERRS + 1);

    localparam logic [LD_W-1:0] LD_LAST   = LD_W'(PRBS_ORDER - 1);
    localparam logic [MC_W-1:0] MC_LAST   = MC_W'(LOCK_COUNT - 1);
    localparam logic [WC_W-1:0] WC_LAST   = WC_W'(WIN_LEN - 1);
    localparam logic [WE_W-1:0] WE_UNLOCK = WE_W'(UNLOCK_ERRS);

    prbs_state_t     st;
    logic [LD_W-1:0] load_cnt;
    logic [MC_W-1:0] match_cnt;
    logic [WC_W-1:0] win_cnt;
    logic [WE_W-1:0] win_err;

    logic pred;
    logic load_zero;
    logic mismatch;
    logic load_en;
    logic adv_en;
    logic [WE_W-1:0] win_err_inc;

    assign mismatch    = rx_data ^ pred;
    assign win_err_inc = win_err + WE_W'(mismatch);
    assign state       = st;

    // A VERIFY mismatch reloads the register with the offending bit so it
    // becomes the first bit of the next search; LOCKED never loads data.
    always_comb begin
        load_en = 1'b0;
        adv_en  = 1'b0;
        if (clk_en) begin
            load_en = (st == ST_SEARCH) || ((st == ST_VERIFY) && mismatch);
            adv_en  = (st == ST_LOCKED) || ((st == ST_VERIFY) && !mismatch);
        end
    end

    prbs_lfsr u_lfsr (
        .emu_clk   (emu_clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_bit  (rx_data),
        .adv_en    (adv_en),
        .pred      (pred),
        .load_zero (load_zero)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge emu_clk or posedge rst) begin
        if (rst) begin
            st        <= ST_SEARCH;
            locked    <= 1'b0;
            err_flag  <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
            load_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else begin
            err_flag <= 1'b0;
            if (clk_en) begin
                case (st)
                    ST_SEARCH: begin
                        if (load_cnt == LD_LAST) begin
                            // an all-zero register would never predict a one
                            load_cnt <= '0;
                            if (!load_zero) begin
                                st <= ST_VERIFY;
                            end
                        end else begin
                            load_cnt <= load_cnt + LD_W'(1);
                        end
                    end
                    ST_VERIFY: begin
                        if (mismatch) begin
                            st        <= ST_SEARCH;
                            load_cnt  <= LD_W'(1);
                            match_cnt <= '0;
                        end else if (match_cnt == MC_LAST) begin
                            st        <= ST_LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + MC_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        bit_count <= sat_inc(bit_count);
                        if (mismatch) begin
                            err_count <= sat_inc(err_count);
                            err_flag  <= 1'b1;
                        end
                        // the current bit's error joins its own window before
                        // the unlock test, even on the window's last bit
                        if (win_err_inc == WE_UNLOCK) begin
                            st      <= ST_SEARCH;
                            locked  <= 1'b0;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else if (win_cnt == WC_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WC_W'(1);
                            win_err <= win_err_inc;
                        end
                    end
                    default: begin
                        st     <= ST_SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clear) begin
                bit_count <= '0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker
module tb_prbs_checker;

    logic        emu_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        clk_en  = 1'b0;
    logic        rx_data = 1'b0;
    logic        clear   = 1'b0;

    logic        locked, err_flag;
    logic [31:0] bit_count, err_count;
    logic [1:0]  state;
    logic        s_locked, s_err_flag;
    logic [3:0]  s_bit_count, s_err_count;
    logic [1:0]  s_state;

    always #5 emu_clk = ~emu_clk;

    prbs_checker dut (
        .emu_clk   (emu_clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .rx_data   (rx_data),
        .clear     (clear),
        .locked    (locked),
        .err_flag  (err_flag),
        .bit_count (bit_count),
        .err_count (err_count),
        .state     (state)
    );

    prbs_checker #(.CNT_W(4)) dut_s (
        .emu_clk   (emu_clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .rx_data   (rx_data),
        .clear     (clear),
        .locked    (s_locked),
        .err_flag  (s_err_flag),
        .bit_count (s_bit_count),
        .err_count (s_err_count),
        .state     (s_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- transmit stream: b[n] = b[n-7] ^ b[n-6] ----------------
    bit tx[$];

    function automatic void tx_reset(input logic [6:0] seed);
        tx.delete();
        for (int i = 6; i >= 0; i--) tx.push_back(seed[i]);
    endfunction

    function automatic bit tx_next();
        bit b;
        b = tx[tx.size()-7] ^ tx[tx.size()-6];
        tx.push_back(b);
        if (tx.size() > 32) void'(tx.pop_front());
        return b;
    endfunction

    // ---------------- reference model over the replica bit sequence ----------
    int     m_mode;     // 0 search, 1 verify, 2 locked
    int     m_loaded, m_match, m_lidx, m_werr;
    bit     m_flag;
    longint m_bits, m_errs;
    bit     rep[$];

    function automatic bit rep_pred();
        return rep[rep.size()-7] ^ rep[rep.size()-6];
    endfunction

    function automatic bit last7_zero();
        for (int i = 1; i <= 7; i++) if (rep[rep.size()-i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_loaded = 0; m_match = 0; m_lidx = 0; m_werr = 0;
        m_flag = 0; m_bits = 0; m_errs = 0;
        rep.delete();
    endfunction

    function automatic void model_step(input bit en, input bit rx, input bit clr);
        bit p;
        m_flag = 0;
        if (en) begin
            if (m_mode == 0) begin
                rep.push_back(rx);
                m_loaded++;
                if (m_loaded == 7) begin
                    m_loaded = 0;
                    if (!last7_zero()) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                p = rep_pred();
                rep.push_back(rx);
                if (rx == p) begin
                    m_match++;
                    if (m_match == 32) begin
                        m_mode = 2; m_match = 0; m_lidx = 0; m_werr = 0;
                    end
                end else begin
                    m_mode = 0; m_loaded = 1; m_match = 0;
                end
            end else begin
                p = rep_pred();
                rep.push_back(p);
                m_bits++;
                if (rx != p) begin
                    m_errs++; m_werr++; m_flag = 1;
                end
                m_lidx++;
                if (m_werr == 8) m_mode = 0;
                else if (m_lidx % 64 == 0) m_werr = 0;
            end
            if (rep.size() > 32) void'(rep.pop_front());
        end
        if (clr) begin
            m_bits = 0; m_errs = 0;
        end
    endfunction

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_outputs();
        chk("locked",      locked,      m_mode == 2);
        chk("err_flag",    err_flag,    m_flag);
        chk("bit_count",   bit_count,   m_bits);
        chk("err_count",   err_count,   m_errs);
        chk("state",       state,       m_mode);
        chk("s_locked",    s_locked,    m_mode == 2);
        chk("s_err_flag",  s_err_flag,  m_flag);
        chk("s_bit_count", s_bit_count, sat4(m_bits));
        chk("s_err_count", s_err_count, sat4(m_errs));
        chk("s_state",     s_state,     m_mode);
    endtask

    task automatic step(input bit en, input bit rx, input bit clr);
        clk_en = en; rx_data = rx; clear = clr;
        @(posedge emu_clk);
        model_step(en, rx, clr);
        #1 check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b0; clear = 1'b0; rx_data = 1'b0;
        @(posedge emu_clk);
        #1;
        model_reset();
        check_outputs();
        rst = 1'b0;
        tx_reset(7'h7F);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int nbits;      // enabled bits applied
        int period;     // one enabled cycle every 'period' cycles
        int e1_start;   // first inverted bit of burst 1 (every 2nd bit)
        int e1_num;
        int e2_start;
        int e2_num;
        int exp_lock_bit;
        int exp_locked;
        int exp_errs;
        int exp_bits;
    } scen_t;

    scen_t tbl[6];

    function automatic bit is_err(input int k, input int i);
        bit a, b;
        a = (tbl[k].e1_num > 0) && (i >= tbl[k].e1_start)
            && (i < tbl[k].e1_start + 2*tbl[k].e1_num) && ((i - tbl[k].e1_start) % 2 == 0);
        b = (tbl[k].e2_num > 0) && (i >= tbl[k].e2_start)
            && (i < tbl[k].e2_start + 2*tbl[k].e2_num) && ((i - tbl[k].e2_start) % 2 == 0);
        return a || b;
    endfunction

    task automatic run_scen(input int k);
        int first_lock;
        bit b;
        first_lock = 0;
        do_reset();
        for (int i = 1; i <= tbl[k].nbits; i++) begin
            b = tx_next();
            if (is_err(k, i)) b = ~b;
            step(1'b1, b, 1'b0);
            if (first_lock == 0 && locked) first_lock = i;
            for (int g = 1; g < tbl[k].period; g++) step(1'b0, b, 1'b0);
        end
        chk($sformatf("s%0d_lock_bit", k),   first_lock,  tbl[k].exp_lock_bit);
        chk($sformatf("s%0d_end_locked", k), locked,      tbl[k].exp_locked);
        chk($sformatf("s%0d_err_count", k),  err_count,   tbl[k].exp_errs);
        chk($sformatf("s%0d_bit_count", k),  bit_count,   tbl[k].exp_bits);
        chk($sformatf("s%0d_s_bits", k),     s_bit_count, sat4(tbl[k].exp_bits));
        chk($sformatf("s%0d_s_errs", k),     s_err_count, sat4(tbl[k].exp_errs));
    endtask

    initial begin
        bit b;
        bit en;
        logic [6:0] seed;

        //          nbits per e1s e1n e2s e2n lock lk errs bits
        tbl[0] = '{100, 1,   0, 0,   0, 0, 39, 1,  0,  61};  // clean
        tbl[1] = '{100, 1,  50, 1,   0, 0, 39, 1,  1,  61};  // single error
        tbl[2] = '{120, 1,  50, 8,   0, 0, 39, 1,  8,  42};  // unlock, relock at 103
        tbl[3] = '{180, 1,  50, 7, 110, 7, 39, 1, 14, 141};  // 7 + 7 across windows
        tbl[4] = '{100, 3,  50, 1,   0, 0, 39, 1,  1,  61};  // clk_en 1-in-3
        tbl[5] = '{150, 1,  89, 8,   0, 0, 39, 1,  8,  72};  // 8th error on window's last bit

        for (int k = 0; k < 6; k++) run_scen(k);

        // all-zero load must not leave SEARCH
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
        chk("zero_stays_search", state, 0);
        for (int i = 0; i < 60; i++) step(1'b1, tx_next(), 1'b0);
        chk("zero_then_lock", locked, 1);

        // clear overrides a same-cycle increment; clk_en=0 holds and masks err_flag
        do_reset();
        for (int i = 0; i < 60; i++) step(1'b1, tx_next(), 1'b0);
        b = ~tx_next();
        step(1'b1, b, 1'b1);
        chk("clr_bits", bit_count, 0);
        chk("clr_errs", err_count, 0);
        chk("clr_flag", err_flag, 1);
        step(1'b0, ~b, 1'b0);
        chk("gap_flag", err_flag, 0);
        chk("gap_bits", bit_count, 0);
        chk("gap_state", state, 2);
        step(1'b1, tx_next(), 1'b0);
        chk("post_gap_bits", bit_count, 1);

        // 4-bit counters saturate; async reset mid-lock
        do_reset();
        for (int i = 0; i < 59; i++) step(1'b1, tx_next(), 1'b0);
        chk("sat_small", s_bit_count, 15);
        chk("sat_big", bit_count, 20);
        step(1'b1, tx_next(), 1'b1);
        chk("sat_clear", s_bit_count, 0);
        for (int i = 0; i < 3; i++) step(1'b1, tx_next(), 1'b0);
        rst = 1'b1;
        #2;
        chk("arst_locked", locked, 0);
        chk("arst_s_locked", s_locked, 0);
        chk("arst_bits", bit_count, 0);
        chk("arst_s_bits", s_bit_count, 0);
        chk("arst_state", state, 0);
        model_reset();
        rst = 1'b0;
        tx_reset(7'h7F);

        // randomized stream, gaps, error injection and clears
        for (int r = 0; r < 4; r++) begin
            do_reset();
            seed = 7'($urandom_range(1, 127));
            tx_reset(seed);
            b = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                en = ($urandom % 4) != 0;
                if (en) begin
                    b = tx_next();
                    if ($urandom % 12 == 0) b = ~b;
                end
                step(en, b, ($urandom % 200) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
